// File: rtl/add_pipe.sv
// add_pipe: LANES-wide pipelined fixed-point adder / butterfly with saturation.
//   Each lane computes out0 = sat(in0 + t) and out1 = sat(in0 - t).
//   t is round(in1*u >> FRAC_WIDTH) when Bf=1, otherwise t is in1.
//   s_add=0 bypasses the lane: out0=in0, out1=in1, ovf=0.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready  : input beat handshake (s_add, in0, in1, u)
//   out_valid/out_ready: output beat handshake (out0, out1, ovf)
//   cnt_clr            : synchronous clear of sat_cnt
//   sat_cnt            : saturating count of delivered beats with any ovf bit
// Three register stages, stall-all on backpressure (no bubble collapsing).

module add_pipe_lane #(
  parameter int BF = 1,
  parameter int W  = 16,
  parameter int F  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld1,
  input  logic         ld2,
  input  logic         ld3,
  input  logic         s_add,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] u,
  output logic [W-1:0] out0,
  output logic [W-1:0] out1,
  output logic         ovf
);
  logic [W-1:0] a1, b1, a2, b2;
  logic [W:0]   t;
  logic [W+1:0] sum_c, dif_c, sum2, dif2;
  logic [W:0]   sat_s, sat_d;

  // Returns {saturated, value}. A W+2 bit result fits in W bits iff its
  // top three bits agree.
  function automatic logic [W:0] sat(input logic [W+1:0] x);
    if (x[W+1:W-1] == 3'b000 || x[W+1:W-1] == 3'b111) return {1'b0, x[W-1:0]};
    else if (x[W+1])                                  return {2'b11, {(W-1){1'b0}}};
    else                                              return {2'b10, {(W-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a1 <= '0;
      b1 <= '0;
    end else if (ld1) begin
      a1 <= in0;
      b1 <= in1;
    end

  if (BF != 0) begin : g_bf
    localparam logic [2*W:0] HALF = {{(2*W){1'b0}}, 1'b1} << (F-1);
    logic signed [2*W-1:0] p1;
    logic signed [2*W:0]   rnd;

    // Operands sign-extended to 2W so the product is exact at 2W bits.
    always_ff @(posedge clk or negedge rst)
      if (!rst)     p1 <= '0;
      else if (ld1) p1 <= $signed({{W{in1[W-1]}}, in1}) * $signed({{W{u[W-1]}}, u});

    // Round half toward +inf, then keep only W+1 bits of the quotient.
    always_comb begin
      rnd = $signed({p1[2*W-1], p1} + HALF);
      t   = (W+1)'(rnd >>> F);
    end
  end else begin : g_nobf
    always_comb t = {b1[W-1], b1};
  end

  always_comb begin
    sum_c = {{2{a1[W-1]}}, a1} + {t[W], t};
    dif_c = {{2{a1[W-1]}}, a1} - {t[W], t};
    sat_s = sat(sum2);
    sat_d = sat(dif2);
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a2   <= '0;
      b2   <= '0;
      sum2 <= '0;
      dif2 <= '0;
    end else if (ld2) begin
      a2   <= a1;
      b2   <= b1;
      sum2 <= sum_c;
      dif2 <= dif_c;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out0 <= '0;
      out1 <= '0;
      ovf  <= 1'b0;
    end else if (ld3) begin
      if (s_add) begin
        out0 <= sat_s[W-1:0];
        out1 <= sat_d[W-1:0];
        ovf  <= sat_s[W] | sat_d[W];
      end else begin
        out0 <= a2;
        out1 <= b2;
        ovf  <= 1'b0;
      end
    end
endmodule

module add_pipe #(
  parameter int Bf              = 1,
  parameter int FIX_POINT_WIDTH = 16,
  parameter int FRAC_WIDTH      = 8,
  parameter int LANES           = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               s_add,
  input  logic [LANES*FIX_POINT_WIDTH-1:0]   in0,
  input  logic [LANES*FIX_POINT_WIDTH-1:0]   in1,
  input  logic [FIX_POINT_WIDTH-1:0]         u,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANES*FIX_POINT_WIDTH-1:0]   out0,
  output logic [LANES*FIX_POINT_WIDTH-1:0]   out1,
  output logic [LANES-1:0]                   ovf,
  input  logic                               cnt_clr,
  output logic [CNT_WIDTH-1:0]               sat_cnt
);
  localparam int W      = FIX_POINT_WIDTH;
  localparam int STAGES = 3;

  logic              en;
  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [2:1]        sadd_q;

  // Whole pipe stalls together whenever a result is waiting for downstream.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign vld_pipe  = {vld_q, in_valid & en};
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst)
    if (!rst)    vld_q <= '0;
    else if (en) vld_q <= vld_pipe[STAGES-1:0];

  // s_add travels with its beat; data regs load only for real beats so
  // bubbles never disturb held outputs.
  always_ff @(posedge clk or negedge rst)
    if (!rst) sadd_q <= '0;
    else begin
      if (vld_pipe[0])       sadd_q[1] <= s_add;
      if (en && vld_pipe[1]) sadd_q[2] <= sadd_q[1];
    end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_pipe_lane #(.BF(Bf), .W(W), .F(FRAC_WIDTH)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .ld1  (vld_pipe[0]),
      .ld2  (en & vld_pipe[1]),
      .ld3  (en & vld_pipe[2]),
      .s_add(sadd_q[2]),
      .in0  (in0[i*W +: W]),
      .in1  (in1[i*W +: W]),
      .u    (u),
      .out0 (out0[i*W +: W]),
      .out1 (out1[i*W +: W]),
      .ovf  (ovf[i])
    );
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)         sat_cnt <= '0;
    else if (cnt_clr) sat_cnt <= '0;
    else if (out_valid && out_ready && (|ovf) && !(&sat_cnt))
      sat_cnt <= sat_cnt + 1'b1;
endmodule

// File: tb/tb_add_pipe.sv
module tb_add_pipe;
  localparam int W = 16, L = 2, F = 8;

  typedef struct {
    logic [L*W-1:0] o0;
    logic [L*W-1:0] o1;
    logic [L-1:0]   ovf;
    int             id;
  } exp_t;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  // main DUT (Bf=1)
  logic in_valid = 0, in_ready, s_add = 0, out_valid, out_ready = 1, cnt_clr = 0;
  logic [L*W-1:0] in0 = '0, in1 = '0, out0, out1;
  logic [W-1:0] u = '0;
  logic [L-1:0] ovf;
  logic [15:0] sat_cnt;

  // second DUT (Bf=0, 2-bit counter)
  logic in_valid_b = 0, in_ready_b, s_add_b = 1, out_valid_b, out_ready_b = 1, cnt_clr_b = 0;
  logic [L*W-1:0] in0_b = '0, in1_b = '0, out0_b, out1_b;
  logic [W-1:0] u_b = '0;
  logic [L-1:0] ovf_b;
  logic [1:0] sat_cnt_b;

  add_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s_add(s_add),
    .in0(in0), .in1(in1), .u(u), .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .ovf(ovf), .cnt_clr(cnt_clr), .sat_cnt(sat_cnt));

  add_pipe #(.Bf(0), .CNT_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .s_add(s_add_b),
    .in0(in0_b), .in1(in1_b), .u(u_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out0(out0_b), .out1(out1_b), .ovf(ovf_b), .cnt_clr(cnt_clr_b), .sat_cnt(sat_cnt_b));

  exp_t sbq[$];
  int checks = 0, errors = 0, beat_id = 0;

  function automatic exp_t mk(input logic [L*W-1:0] o0, o1, input logic [L-1:0] v);
    exp_t e;
    e.o0 = o0; e.o1 = o1; e.ovf = v; e.id = 0;
    return e;
  endfunction

  // Reference: integer arithmetic on longint, clamp by comparison.
  function automatic exp_t model(input logic [L*W-1:0] a, b, input logic [W-1:0] uu, input bit sa);
    exp_t e;
    longint hi, lo;
    hi = (64'sd1 <<< (W-1)) - 1;
    lo = -(64'sd1 <<< (W-1));
    e = mk('0, '0, '0);
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] al, bl;
      longint x, y, t, s, d;
      al = a[i*W +: W];
      bl = b[i*W +: W];
      if (!sa) begin
        e.o0[i*W +: W] = al;
        e.o1[i*W +: W] = bl;
        continue;
      end
      x = longint'($signed(al));
      y = longint'($signed(bl));
      t = (y * longint'($signed(uu)) + (64'sd1 <<< (F-1))) >>> F;
      t = t & ((64'sd1 <<< (W+1)) - 1);
      if (t >= (64'sd1 <<< W)) t = t - (64'sd1 <<< (W+1));
      s = x + t;
      d = x - t;
      if (s > hi) begin s = hi; e.ovf[i] = 1'b1; end
      else if (s < lo) begin s = lo; e.ovf[i] = 1'b1; end
      if (d > hi) begin d = hi; e.ovf[i] = 1'b1; end
      else if (d < lo) begin d = lo; e.ovf[i] = 1'b1; end
      e.o0[i*W +: W] = s[W-1:0];
      e.o1[i*W +: W] = d[W-1:0];
    end
    return e;
  endfunction

  // Present a beat on the main DUT; returns just after its handshake edge.
  task automatic drive(input logic [L*W-1:0] a, b, input logic [W-1:0] uu, input bit sa, input exp_t e);
    bit acc = 0;
    in_valid = 1; in0 = a; in1 = b; u = uu; s_add = sa;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.id = beat_id++;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    checks++;
    if (!acc) begin errors++; $display("FAIL drive_accept: in_ready stayed 0, required 1"); end
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 0 || out0 !== '0 || out1 !== '0 || ovf !== '0 || sat_cnt !== '0) begin
      errors++;
      $display("FAIL reset_state: ov=%b o0=%h o1=%h ovf=%b cnt=%0d, required all 0", out_valid, out0, out1, ovf, sat_cnt);
    end
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_bf0();
    in_valid_b = 1; s_add_b = 1; u_b = 16'hABCD;
    in0_b = {16'd5, 16'd1}; in1_b = {16'd3, 16'd2};
    @(posedge clk); #1 in_valid_b = 0;
    @(posedge clk); #1;
    checks++;
    if (out_valid_b !== 0) begin errors++; $display("FAIL bf0_early: out_valid=%b, required 0", out_valid_b); end
    @(posedge clk); #1;
    checks++;
    if (out_valid_b !== 1 || out0_b !== {16'h0008, 16'h0003} || out1_b !== {16'h0002, 16'hFFFF} || ovf_b !== 2'b00) begin
      errors++;
      $display("FAIL bf0_result: ov=%b o0=%h o1=%h ovf=%b, required 1 00080003 0002ffff 00", out_valid_b, out0_b, out1_b, ovf_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cnt_sat();
    in0_b = {16'h7000, 16'h7000}; in1_b = {16'h7000, 16'h7000}; s_add_b = 1;
    for (int k = 0; k < 5; k++) begin
      in_valid_b = 1;
      @(posedge clk); #1;
    end
    in_valid_b = 0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (sat_cnt_b !== 2'd3) begin errors++; $display("FAIL cnt_saturate: sat_cnt=%0d, required 3", sat_cnt_b); end
    checks++;
    if (out0_b !== {16'h7FFF, 16'h7FFF} || out1_b !== '0 || ovf_b !== 2'b11) begin
      errors++;
      $display("FAIL bf0_sat: o0=%h o1=%h ovf=%b, required 7fff7fff 00000000 11", out0_b, out1_b, ovf_b);
    end
  endtask

  task automatic test_bf1();
    drive({16'h0100, 16'h0100}, {16'h0200, 16'h0200}, 16'h0080, 1,
          mk({16'h0200, 16'h0200}, '0, 2'b00));
    wait_empty();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL bf1_drain: %0d left, required 0", sbq.size()); end
  endtask

  task automatic test_round();
    drive('0, {16'hFF80, 16'h0080}, 16'h0001, 1, mk({16'h0000, 16'h0001}, {16'h0000, 16'hFFFF}, 2'b00));
    drive('0, {16'h0081, 16'hFF7F}, 16'h0001, 1, mk({16'h0001, 16'hFFFF}, {16'hFFFF, 16'h0001}, 2'b00));
    wait_empty();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL round_drain: %0d left, required 0", sbq.size()); end
  endtask

  task automatic test_bypass();
    drive({16'h7FFF, 16'h8000}, {16'h1234, 16'h8001}, 16'h0100, 0,
          mk({16'h7FFF, 16'h8000}, {16'h1234, 16'h8001}, 2'b00));
    wait_empty();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL bypass_drain: %0d left, required 0", sbq.size()); end
  endtask

  task automatic test_sat();
    bit seen = 0;
    drive({16'h0010, 16'h7F00}, {16'h0020, 16'h7F00}, 16'h0100, 1,
          mk({16'h0030, 16'h7FFF}, {16'hFFF0, 16'h0000}, 2'b01));
    wait_empty();
    checks++;
    if (sat_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt1: %0d, required 1", sat_cnt); end
    drive({16'h0010, 16'h8000}, {16'h0020, 16'h7F00}, 16'h0100, 1,
          mk({16'h0030, 16'hFF00}, {16'hFFF0, 16'h8000}, 2'b01));
    wait_empty();
    checks++;
    if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt2: %0d, required 2", sat_cnt); end
    drive({16'h0010, 16'h7F00}, {16'h0020, 16'h7F00}, 16'h0100, 1,
          mk({16'h0030, 16'h7FFF}, {16'hFFF0, 16'h0000}, 2'b01));
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_valid) seen = 1;
      else begin @(posedge clk); #1; end
    end
    cnt_clr = 1;
    @(posedge clk); #1 cnt_clr = 0;
    checks++;
    if (!seen || sat_cnt !== 16'd0) begin
      errors++; $display("FAIL cnt_clr_priority: seen=%b sat_cnt=%0d, required 1 0", seen, sat_cnt);
    end
    wait_empty();
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic [L*W-1:0] a, b;
          a = {16'(k + 100), 16'(k)};
          b = {16'h0001, 16'h0001};
          drive(a, b, 16'h0100, 1, model(a, b, 16'h0100, 1));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 0 || out_valid !== 1) begin
            errors++; $display("FAIL stall_in_ready: in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
          end
        end
        @(posedge clk); #1 out_ready = 1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1) begin errors++; $display("FAIL unstall_in_ready: %b, required 1", in_ready); end
      end
    join
    wait_empty();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL b2b_drain: %0d left, required 0", sbq.size()); end
  endtask

  task automatic test_random();
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          logic [L*W-1:0] a, b;
          logic [W-1:0] uu;
          bit sa;
          a = {16'($urandom), 16'($urandom)};
          b = {16'($urandom), 16'($urandom)};
          uu = 16'($urandom);
          sa = ($urandom_range(0, 3) != 0);
          drive(a, b, uu, sa, model(a, b, uu, sa));
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1;
      end
    join
    out_ready = 1;
    wait_empty();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL random_drain: %0d left, required 0", sbq.size()); end
  endtask

  task automatic test_reset_mid();
    bit stale = 0;
    drive({16'h0000, 16'h7F00}, {16'h0000, 16'h7F00}, 16'h0100, 1,
          mk({16'h0000, 16'h7FFF}, '0, 2'b01));
    wait_empty();
    checks++;
    if (sat_cnt === 16'd0) begin errors++; $display("FAIL pre_reset_cnt: sat_cnt=0, required nonzero"); end
    for (int k = 0; k < 3; k++)
      drive({16'h7000, 16'h7000}, {16'h7000, 16'h7000}, 16'h0100, 1, mk('1, '1, '1));
    #2 rst = 0;
    sbq.delete();
    #1;
    checks++;
    if (out_valid !== 0 || out0 !== '0 || out1 !== '0 || ovf !== '0 || sat_cnt !== '0) begin
      errors++;
      $display("FAIL async_reset: ov=%b o0=%h o1=%h ovf=%b cnt=%0d, required all 0", out_valid, out0, out1, ovf, sat_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 0) stale = 1;
    end
    checks++;
    if (stale) begin errors++; $display("FAIL stale_beat: out_valid=1 after reset, required 0"); end
    @(posedge clk); #1;
    drive({16'h0002, 16'h0001}, {16'h0001, 16'h0001}, 16'h0100, 1,
          mk({16'h0003, 16'h0002}, {16'h0001, 16'h0000}, 2'b00));
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL post_reset_early: out_valid=%b, required 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1) begin errors++; $display("FAIL post_reset_latency: out_valid=%b, required 1", out_valid); end
    wait_empty();
  endtask

  initial begin
    fork
      begin : monitor
        bit hold_p = 0;
        logic [L*W-1:0] h0, h1;
        logic [L-1:0] hv;
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin hold_p = 0; continue; end
          if (hold_p) begin
            checks++;
            if (out_valid !== 1 || out0 !== h0 || out1 !== h1 || ovf !== hv) begin
              errors++;
              $display("FAIL hold: ov=%b o0=%h o1=%h ovf=%b, required 1 %h %h %b", out_valid, out0, out1, ovf, h0, h1, hv);
            end
          end
          if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
              errors++; $display("FAIL unexpected_beat: o0=%h o1=%h, required none", out0, out1);
            end else begin
              e = sbq.pop_front();
              if (out0 !== e.o0 || out1 !== e.o1 || ovf !== e.ovf) begin
                errors++;
                $display("FAIL beat%0d: o0=%h o1=%h ovf=%b, required %h %h %b", e.id, out0, out1, ovf, e.o0, e.o1, e.ovf);
              end
            end
          end
          hold_p = out_valid && !out_ready;
          h0 = out0; h1 = out1; hv = ovf;
        end
      end
    join_none
    test_reset();
    test_bf0();
    test_cnt_sat();
    test_bf1();
    test_round();
    test_bypass();
    test_sat();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/add_pipe.md
Name: add_pipe

Overview:
- Parametrised, pipelined successor to the single-lane combinational fixed-point add/butterfly unit.
- Processes LANES independent signed fixed-point lanes in parallel.
- Each lane optionally scales in1 by a shared coefficient u (Bf mode) and produces a saturated sum and difference.
- Sits between operand fetch and the nonlinear-function evaluators, with a valid/ready handshake on both sides and an overflow-statistics counter.

Parameters:
- Bf, 1, 1 = butterfly mode: t = round(in1*u >> FRAC_WIDTH); 0 = t = in1, u ignored.
- FIX_POINT_WIDTH, 16, width W of every signed two's-complement operand and result.
- FRAC_WIDTH, 8, fractional bits of u; valid range 1..W-1.
- LANES, 2, number of parallel lanes.
- CNT_WIDTH, 16, width of the overflow statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- s_add  in  1  sampled with the beat; 1 = add/sub, 0 = bypass.
- in0  in  LANES*W  lane i at bits [i*W +: W].
- in1  in  LANES*W  lane i at bits [i*W +: W].
- u  in  W  shared coefficient, sampled with the beat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the beat.
- out0  out  LANES*W  per-lane in0 + t (saturated).
- out1  out  LANES*W  per-lane in0 - t (saturated).
- ovf  out  LANES  per-lane saturation flag for the current output beat.
- cnt_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_WIDTH  number of accepted output beats with any ovf bit set.

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, out0, out1, ovf, out_valid and sat_cnt go to 0. in_ready is 1 once reset is released. A beat in flight when reset asserts is discarded, with no partial output.
- Pipeline: 3 register stages. Input handshake is in_valid && in_ready; output handshake is out_valid && out_ready.
  - S1 registers operands and, when Bf=1, the signed product in1*u (2W bits).
  - S2 forms t and computes sum = in0 + t and dif = in0 - t at W+2 bits, sign-extended.
  - S3 saturates the results and registers out0, out1, ovf and out_valid.
- Latency is 3 cycles from input handshake to out_valid with no stall. Throughput is 1 beat per cycle.
- Stall: en = !out_valid || out_ready, and in_ready = en (combinational). All stages and valid bits advance only when en=1. Bubbles are not collapsed. Data and order are preserved under any out_ready pattern.
- Output hold: out0, out1, ovf and out_valid hold stable while out_valid=1 and out_ready=0.
- Rounding (Bf=1):
  - t = (in1*u + 2^(FRAC_WIDTH-1)) >>> FRAC_WIDTH, an arithmetic shift (round half toward +infinity).
  - t is kept at W+1 bits before the add.
  - With Bf=0, t = in1 sign-extended.
- Saturation: a result above 2^(W-1)-1 becomes 0x7FFF (for W=16); a result below -2^(W-1) becomes 0x8000. ovf[i] = 1 if either out0 or out1 of lane i saturated.
- Bypass (s_add=0): out0 = in0 and out1 = in1 unmodified, ovf = 0. Latency is still 3 cycles.
- sat_cnt:
  - Increments by 1 on each output handshake where |ovf=1.
  - Saturates at all-ones and does not wrap.
  - cnt_clr=1 forces 0 on the next edge and takes priority over a simultaneous increment.
- Out-of-beat inputs: when in_valid=0, s_add, u and the operands are don't-care. in_valid may drop at any time without loss of accepted beats.

Test Plan:
1. Bf=0, LANES=2, lane0: in0=1, in1=2, s_add=1, out_ready=1 -> 3 cycles later out0 lane0 = 0x0003, out1 lane0 = 0xFFFF, ovf=0.
2. Bf=1, FRAC=8, u=0x0080, in0=0x0100, in1=0x0200 -> t=0x0100, out0=0x0200, out1=0x0000.
3. Rounding, u=0x0001:
   - in1=0x0080 -> t=1.
   - in1=0xFF80 -> t=0.
   - in1=0xFF7F -> t=-1 (0xFFFF).
4. Bf=1, u=0x0100, in0=in1=0x7F00 -> out0=0x7FFF, out1=0x0000, ovf[0]=1, sat_cnt=1. Then in0=0x8000, in1=0x7F00 -> out1=0x8000, sat_cnt=2. Assert cnt_clr together with a third overflow beat -> sat_cnt=0.
5. Backpressure: 8 back-to-back beats with in0 = k (k = 0..7), out_ready=0 for 3 cycles mid-stream -> in_ready low exactly while stalled, outputs held, all 8 results delivered in order with none lost or duplicated.
6. Reset mid-operation: assert rst=0 with 3 beats in flight -> outputs, out_valid and sat_cnt are 0 immediately (asynchronously). After release, no stale beat appears and a new beat has 3-cycle latency.
